// File: rtl/mips16_pkg.sv
// Shared definitions for the Mips16 core and its boot-time instruction loader.
package mips16_pkg;

    localparam int WORD_W     = 16;
    localparam int IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PCRST = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } imem_ld_state_t;

endpackage

// File: rtl/imem_ld_cksum.sv
// Running modulo-2^16 sum of the instruction words of one load.
// Clearing and adding in the same cycle restarts the sum at the new word.
module imem_ld_cksum
    import mips16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add_en,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] sum
);

    logic [WORD_W-1:0] sum_q;
    logic [WORD_W-1:0] sum_d;

    // Next sum: clear, accumulate or hold.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = add_en ? data : '0;
        end else if (add_en) begin
            sum_d = sum_q + data;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction loader: streams program words into instruction memory,
// rewinds the PC, then enables fetch.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (last word is a checksum).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for the first word of a program, word_count = 0
// ST_LOAD  | accepting program words, one wen per stored word
// ST_PCRST | pc_reset held high for PC_RST_CYCLES cycles
// ST_RUN   | rd_en high, core fetching; restart returns to IDLE
// ST_ERROR | overflow or checksum mismatch; sticky until restart
module imem_loader
    import mips16_pkg::*;
#(
    parameter int DEPTH         = IMEM_DEPTH,
    parameter int PC_RST_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_valid,
    input  logic [WORD_W-1:0]        host_data,
    input  logic                     host_last,
    output logic                     host_ready,
    input  logic                     restart,
    output logic [WORD_W-1:0]        din,
    output logic                     wen,
    output logic                     pc_reset,
    output logic                     rd_en,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     error
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PCC_W = (PC_RST_CYCLES > 1) ? $clog2(PC_RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [PCC_W-1:0] PCC_LOAD = PCC_W'(PC_RST_CYCLES - 1);

    imem_ld_state_t    state_q, state_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              wen_q, wen_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [PCC_W-1:0]  pc_cnt_q, pc_cnt_d;
    logic              accept;

    assign host_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept     = host_valid && host_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] cksum_sum;
    logic [WORD_W-1:0] cksum_ref;

    // The accumulator still holds the previous load's sum on the first IDLE
    // cycle after restart, so a lone checksum word in IDLE compares against 0.
    assign cksum_ref = (state_q == ST_IDLE) ? '0 : cksum_sum;

    imem_ld_cksum u_cksum (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q == ST_IDLE),
        .add_en (wen_d),
        .data   (host_data),
        .sum    (cksum_sum)
    );
`endif

    // Next-state, write strobe, word counter and pc_reset timer.
    always_comb begin
        state_d      = state_q;
        din_d        = din_q;
        wen_d        = 1'b0;
        word_count_d = word_count_q;
        pc_cnt_d     = pc_cnt_q;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (host_last) begin
                        if (host_data == cksum_ref) begin
                            state_d  = ST_PCRST;
                            pc_cnt_d = PCC_LOAD;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else if (word_count_q == FULL) begin
                        state_d = ST_ERROR;
                    end else begin
                        din_d        = host_data;
                        wen_d        = 1'b1;
                        word_count_d = word_count_q + 1'b1;
                        state_d      = ST_LOAD;
                    end
`else
                    if (word_count_q == FULL) begin
                        state_d = ST_ERROR;
                    end else begin
                        din_d        = host_data;
                        wen_d        = 1'b1;
                        word_count_d = word_count_q + 1'b1;
                        if (host_last) begin
                            state_d  = ST_PCRST;
                            pc_cnt_d = PCC_LOAD;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
`endif
                end
            end
            ST_PCRST: begin
                if (pc_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    pc_cnt_d = pc_cnt_q - 1'b1;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (restart) begin
                    state_d      = ST_IDLE;
                    word_count_d = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                word_count_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            din_q        <= '0;
            wen_q        <= 1'b0;
            word_count_q <= '0;
            pc_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            wen_q        <= wen_d;
            word_count_q <= word_count_d;
            pc_cnt_q     <= pc_cnt_d;
        end
    end

    assign din        = din_q;
    assign wen        = wen_q;
    assign word_count = word_count_q;
    assign pc_reset   = (state_q == ST_PCRST);
    assign rd_en      = (state_q == ST_RUN);
    assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a timeline-based reference model.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int PCR   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_valid;
    logic [15:0] host_data;
    logic        host_last;
    logic        host_ready;
    logic        restart;
    logic [15:0] din;
    logic        wen;
    logic        pc_reset;
    logic        rd_en;
    logic [$clog2(DEPTH):0] word_count;
    logic        error;

    int vectors = 0;
    int errors  = 0;

    imem_loader #(.DEPTH(DEPTH), .PC_RST_CYCLES(PCR)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .restart    (restart),
        .din        (din),
        .wen        (wen),
        .pc_reset   (pc_reset),
        .rd_en      (rd_en),
        .word_count (word_count),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Reference model: counts stored words and remembers the cycle in which the
    // program completed; pc_reset / rd_en follow from that timestamp.
    int          cyc    = 0;
    int          m_cnt  = 0;
    bit          m_err  = 0;
    int          m_last = -1;
    logic [15:0] m_sum  = 0;
    bit          e_wen  = 0;
    logic [15:0] e_din  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_err = 0; m_last = -1; m_sum = 0; e_wen = 0; e_din = 0;
        end else begin
            int  pre;
            bit  rdy, in_run;
            pre    = cyc;
            rdy    = !m_err && (m_last < 0);
            in_run = (m_last >= 0) && (pre >= m_last + PCR + 1);
            e_wen  = 0;
            if (host_valid && rdy) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (host_last) begin
                    if (host_data == m_sum) m_last = pre;
                    else m_err = 1;
                end else if (m_cnt == DEPTH) begin
                    m_err = 1;
                end else begin
                    e_wen = 1; e_din = host_data; m_cnt++; m_sum = m_sum + host_data;
                end
`else
                if (m_cnt == DEPTH) begin
                    m_err = 1;
                end else begin
                    e_wen = 1; e_din = host_data; m_cnt++;
                    if (host_last) m_last = pre;
                end
`endif
            end else if (restart && (m_err || in_run)) begin
                m_err = 0; m_last = -1; m_cnt = 0; m_sum = 0;
            end
            cyc = cyc + 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            cmp("rst_wen", int'(wen), 0);
            cmp("rst_din", int'(din), 0);
            cmp("rst_pc_reset", int'(pc_reset), 0);
            cmp("rst_rd_en", int'(rd_en), 0);
            cmp("rst_word_count", int'(word_count), 0);
            cmp("rst_error", int'(error), 0);
        end else begin
            bit e_pc, e_rd;
            e_pc = (m_last >= 0) && (cyc >= m_last + 1) && (cyc <= m_last + PCR);
            e_rd = (m_last >= 0) && (cyc >= m_last + PCR + 1);
            cmp("wen", int'(wen), int'(e_wen));
            cmp("din", int'(din), int'(e_din));
            cmp("word_count", int'(word_count), m_cnt);
            cmp("pc_reset", int'(pc_reset), int'(e_pc));
            cmp("rd_en", int'(rd_en), int'(e_rd));
            cmp("error", int'(error), int'(m_err));
            cmp("host_ready", int'(host_ready), int'(!m_err && (m_last < 0)));
            cmp("pc_rd_excl", int'(pc_reset & rd_en), 0);
            cmp("wen_rd_excl", int'(wen & rd_en), 0);
        end
    end

    // Capture of written words and pc_reset width for literal checks.
    logic [15:0] wq[$];
    int          pc_cycles = 0;
    always @(negedge clk) begin
        if (reset && wen) wq.push_back(din);
        if (reset && pc_reset) pc_cycles++;
    end

    task automatic clear_capture();
        wq.delete();
        pc_cycles = 0;
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        host_valid = 1'b1; host_data = d; host_last = l;
        @(negedge clk);
        host_valid = 1'b0; host_last = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic check_words(input string name, input logic [15:0] exp[$]);
        cmp({name, "_nwrites"}, wq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wq.size(); i++)
            cmp({name, "_word"}, int'(wq[i]), int'(exp[i]));
    endtask

    initial begin
        reset = 1'b0; host_valid = 1'b0; host_data = '0; host_last = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cmp("lit_ready_after_reset", int'(host_ready), 1);
        cmp("lit_count_after_reset", int'(word_count), 0);

        // Back-to-back three-word program.
        clear_capture();
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        push(16'h3333, 1'b1);
        repeat (5) @(negedge clk);
        check_words("b2b", '{16'h1111, 16'h2222, 16'h3333});
        cmp("lit_b2b_pc_width", pc_cycles, 2);
        cmp("lit_b2b_rd_en", int'(rd_en), 1);
        cmp("lit_b2b_count", int'(word_count), 3);
        do_restart();
        cmp("lit_restart_rd_low", int'(rd_en), 0);
        cmp("lit_restart_count", int'(word_count), 0);
        @(negedge clk);

        // Same program with valid toggling.
        clear_capture();
        push(16'h1111, 1'b0);
        @(negedge clk);
        push(16'h2222, 1'b0);
        @(negedge clk);
        push(16'h3333, 1'b1);
        repeat (5) @(negedge clk);
        check_words("gap", '{16'h1111, 16'h2222, 16'h3333});
        cmp("lit_gap_count", int'(word_count), 3);
        do_restart();
        @(negedge clk);

        // Overflow: five words into a four-word memory.
        clear_capture();
        push(16'hA001, 1'b0);
        push(16'hA002, 1'b0);
        push(16'hA003, 1'b0);
        push(16'hA004, 1'b0);
        push(16'hA005, 1'b1);
        repeat (4) @(negedge clk);
        check_words("ovf", '{16'hA001, 16'hA002, 16'hA003, 16'hA004});
        cmp("lit_ovf_error", int'(error), 1);
        cmp("lit_ovf_rd_en", int'(rd_en), 0);
        cmp("lit_ovf_pc", pc_cycles, 0);
        do_restart();
        cmp("lit_ovf_error_clr", int'(error), 0);
        cmp("lit_ovf_ready", int'(host_ready), 1);
        @(negedge clk);

        // Reset mid-load, then a fresh one-word load.
        push(16'hB001, 1'b0);
        push(16'hB002, 1'b0);
        #2 reset = 1'b0;
        #1;
        cmp("lit_midrst_wen", int'(wen), 0);
        cmp("lit_midrst_count", int'(word_count), 0);
        cmp("lit_midrst_din", int'(din), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_capture();
        push(16'hABCD, 1'b1);
        repeat (4) @(negedge clk);
        check_words("one", '{16'hABCD});
        cmp("lit_one_count", int'(word_count), 1);
        cmp("lit_one_rd_en", int'(rd_en), 1);
        do_restart();
        @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        clear_capture();
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0003, 1'b1);
        repeat (4) @(negedge clk);
        check_words("ck_ok", '{16'h0001, 16'h0002});
        cmp("lit_ck_ok_rd_en", int'(rd_en), 1);
        do_restart();
        @(negedge clk);
        clear_capture();
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0004, 1'b1);
        repeat (4) @(negedge clk);
        cmp("lit_ck_bad_error", int'(error), 1);
        cmp("lit_ck_bad_pc", pc_cycles, 0);
        do_restart();
        @(negedge clk);
`endif

        // Restart ignored in PCRST, honoured in RUN, then reload.
`ifdef IMEM_LOADER_CHECKSUM_EN
        push(16'h5555, 1'b0);
        push(16'h5555, 1'b1);
`else
        push(16'h5555, 1'b0);
        push(16'h6666, 1'b1);
`endif
        cmp("lit_pcrst_pc", int'(pc_reset), 1);
        do_restart();
        repeat (3) @(negedge clk);
        cmp("lit_pcrst_restart_ignored", int'(rd_en), 1);
        do_restart();
        cmp("lit_run_restart_rd_low", int'(rd_en), 0);
        @(negedge clk);
        clear_capture();
        push(16'h0007, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push(16'h0008, 1'b0);
        push(16'h000F, 1'b1);
`else
        push(16'h0008, 1'b1);
`endif
        repeat (4) @(negedge clk);
        check_words("reload", '{16'h0007, 16'h0008});
        cmp("lit_reload_rd_en", int'(rd_en), 1);
        cmp("lit_reload_count", int'(word_count), 2);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
